// File: rtl/sd_fifo_tailwr_thr.sv
// sd_fifo_tailwr_thr: tail-write shift FIFO with flush, programmable
// almost-full / almost-empty flags and an optional high-watermark monitor.
// Valid entries are packed against the tail (index depth-1). Writes shift
// the whole buffer down one slot, and reads only move the head index.
// The write-side ready depends on local state and flush only, never on
// p_drdy, so the two handshakes are decoupled.
// Optional feature: define SD_TAILWR_HWM_EN to build the peak-usage
// register. Without it, hwm is tied to zero and hwm_clr is ignored.
module sd_fifo_tailwr_thr #(
  parameter int width = 8,
  parameter int depth = 16,
  parameter int usz   = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] c_data,
  input  logic             c_srdy,
  output logic             c_drdy,
  output logic [width-1:0] p_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  input  logic             flush,
  input  logic [usz-1:0]   af_thresh,
  input  logic [usz-1:0]   ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [usz-1:0]   usage,
  output logic [usz-1:0]   nxt_usage,
  output logic [usz-1:0]   hwm,
  input  logic             hwm_clr
);

  localparam logic [usz-1:0] DEPTH_U = usz'(depth);

  logic [width-1:0] data_buf [depth];
  logic             wr;
  logic             rd;
  logic [usz-1:0]   head_idx;

  // Ready/valid come from the registered count only. Flush blocks writes.
  assign c_drdy   = (usage < DEPTH_U) & ~flush;
  assign p_srdy   = (usage != '0);
  assign wr       = c_srdy & c_drdy;
  assign rd       = p_srdy & p_drdy;
  assign head_idx = DEPTH_U - usage;

  // Next occupancy. Flush wins over any handshake, and the count never wraps.
  always_comb begin
    if (flush) begin
      nxt_usage = '0;
    end else begin
      nxt_usage = usage + {{(usz-1){1'b0}}, wr} - {{(usz-1){1'b0}}, rd};
    end
  end

  // Head-of-FIFO mux. When the FIFO is empty, head_idx equals depth and nothing matches.
  always_comb begin
    p_data = '0;
    for (int i = 0; i < depth; i++) begin
      if (head_idx == usz'(i)) p_data = data_buf[i];
    end
  end

  // Data path: on a write, shift toward index 0 and load the newest entry at the tail.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < depth - 1; i++) begin
        data_buf[i] <= data_buf[i+1];
      end
      data_buf[depth-1] <= c_data;
    end
  end

  // Control state: occupancy and registered threshold flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      usage        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      usage        <= nxt_usage;
      almost_full  <= (nxt_usage >= af_thresh);
      almost_empty <= (nxt_usage <= ae_thresh);
    end
  end

`ifdef SD_TAILWR_HWM_EN
  logic [usz-1:0] hwm_r;

  // Peak-usage tracker. A clear reloads the current level, and flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_r <= '0;
    end else if (hwm_clr) begin
      hwm_r <= nxt_usage;
    end else if (nxt_usage > hwm_r) begin
      hwm_r <= nxt_usage;
    end
  end

  assign hwm = hwm_r;
`else
  logic unused_hwm_clr;

  assign unused_hwm_clr = hwm_clr;
  assign hwm            = '0;
`endif

endmodule

// File: tb/tb_sd_fifo_tailwr_thr.sv
// Testbench for sd_fifo_tailwr_thr (depth=4, width=8). A data scoreboard
// queue is filled on accepted writes and drained on reads. A small
// occupancy/flag/watermark model predicts the control outputs.
module tb_sd_fifo_tailwr_thr;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int USZ = 3;
  localparam logic [USZ-1:0] DEPTH_U = 3'd4;

  logic           clk;
  logic           reset;
  logic [W-1:0]   c_data;
  logic           c_srdy;
  logic           c_drdy;
  logic [W-1:0]   p_data;
  logic           p_srdy;
  logic           p_drdy;
  logic           flush;
  logic [USZ-1:0] af_thresh;
  logic [USZ-1:0] ae_thresh;
  logic           almost_full;
  logic           almost_empty;
  logic [USZ-1:0] usage;
  logic [USZ-1:0] nxt_usage;
  logic [USZ-1:0] hwm;
  logic           hwm_clr;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   sb[$];
  logic [USZ-1:0] m_usage = '0;
  logic           m_af    = 1'b0;
  logic           m_ae    = 1'b1;
  logic [USZ-1:0] m_hwm   = '0;

  sd_fifo_tailwr_thr #(.width(W), .depth(D), .usz(USZ)) dut (
    .clk(clk), .reset(reset),
    .c_data(c_data), .c_srdy(c_srdy), .c_drdy(c_drdy),
    .p_data(p_data), .p_srdy(p_srdy), .p_drdy(p_drdy),
    .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .usage(usage), .nxt_usage(nxt_usage),
    .hwm(hwm), .hwm_clr(hwm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus. It checks handshakes and the scoreboard before the edge, then checks the model state after the edge.
  task automatic cyc(input logic cs, input logic [W-1:0] cd, input logic pd, input logic fl);
    logic           wr_m;
    logic           rd_m;
    logic           cdrdy_m;
    logic [USZ-1:0] nu;
    logic [W-1:0]   exp_d;
    c_srdy = cs; c_data = cd; p_drdy = pd; flush = fl;
    #1;
    cdrdy_m = (m_usage < DEPTH_U) & ~fl;
    wr_m    = cs & cdrdy_m;
    rd_m    = pd & (m_usage != '0);
    checks++;
    if (c_drdy !== cdrdy_m) begin
      errors++; $display("FAIL c_drdy: got %b expected %b (usage %0d)", c_drdy, cdrdy_m, m_usage);
    end
    checks++;
    if (p_srdy !== (m_usage != '0)) begin
      errors++; $display("FAIL p_srdy: got %b expected %b", p_srdy, (m_usage != '0));
    end
    if (rd_m) begin
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL scoreboard: read with empty queue");
      end else begin
        exp_d = sb.pop_front();
        checks++;
        if (p_data !== exp_d) begin
          errors++; $display("FAIL p_data: got %02h expected %02h", p_data, exp_d);
        end
      end
    end
    if (fl) sb.delete();
    else if (wr_m) sb.push_back(cd);
    nu = fl ? '0 : USZ'(m_usage + USZ'(wr_m) - USZ'(rd_m));
    checks++;
    if (nxt_usage !== nu) begin
      errors++; $display("FAIL nxt_usage: got %0d expected %0d", nxt_usage, nu);
    end
    @(posedge clk);
    #1;
    m_usage = nu;
    m_af    = (nu >= af_thresh);
    m_ae    = (nu <= ae_thresh);
`ifdef SD_TAILWR_HWM_EN
    m_hwm   = hwm_clr ? nu : ((nu > m_hwm) ? nu : m_hwm);
`endif
    checks++;
    if (usage !== m_usage) begin
      errors++; $display("FAIL usage: got %0d expected %0d", usage, m_usage);
    end
    checks++;
    if (almost_full !== m_af) begin
      errors++; $display("FAIL almost_full: got %b expected %b", almost_full, m_af);
    end
    checks++;
    if (almost_empty !== m_ae) begin
      errors++; $display("FAIL almost_empty: got %b expected %b", almost_empty, m_ae);
    end
    checks++;
    if (hwm !== m_hwm) begin
      errors++; $display("FAIL hwm: got %0d expected %0d", hwm, m_hwm);
    end
    c_srdy = 1'b0; p_drdy = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; c_srdy = 0; c_data = '0; p_drdy = 0; flush = 0; hwm_clr = 0;
    af_thresh = 3'd5; ae_thresh = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (usage !== 3'd0) begin errors++; $display("FAIL rst_usage: got %0d expected 0", usage); end
    checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL rst_c_drdy: got %b expected 1", c_drdy); end
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL rst_p_srdy: got %b expected 0", p_srdy); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b expected 0", almost_full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b expected 1", almost_empty); end
    checks++; if (hwm !== 3'd0) begin errors++; $display("FAIL rst_hwm: got %0d expected 0", hwm); end
    reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) cyc(1'b1, vals[i], 1'b0, 1'b0);
    checks++; if (c_drdy !== 1'b0) begin errors++; $display("FAIL full_c_drdy: got %b expected 0", c_drdy); end
    checks++; if (usage !== 3'd4) begin errors++; $display("FAIL full_usage: got %0d expected 4", usage); end
    checks++; if (p_data !== 8'h11) begin errors++; $display("FAIL full_head: got %02h expected 11", p_data); end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL drained_p_srdy: got %b expected 0", p_srdy); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (usage > 3'd4 || usage < 3'd3) begin
        errors++; $display("FAIL full_simul_usage: got %0d expected 3..4", usage);
      end
    end
    while (m_usage != '0) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h42 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (usage !== 3'd2) begin errors++; $display("FAIL b2b_usage: got %0d expected 2", usage); end
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_flush();
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    cyc(1'b1, 8'hC4, 1'b1, 1'b1);
    checks++; if (usage !== 3'd0) begin errors++; $display("FAIL flush_usage: got %0d expected 0", usage); end
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL flush_p_srdy: got %b expected 0", p_srdy); end
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++; if (p_data !== 8'h5A) begin errors++; $display("FAIL post_flush_data: got %02h expected 5a", p_data); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_thresholds();
    af_thresh = 3'd3; ae_thresh = 3'd1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL ae_u0: got %b expected 1", almost_empty); end
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL ae_u1: got %b expected 1", almost_empty); end
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL ae_u2: got %b expected 0", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_u2: got %b expected 0", almost_full); end
    cyc(1'b1, 8'h63, 1'b0, 1'b0);
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_u3: got %b expected 1", almost_full); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    af_thresh = 3'd0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_zero_thresh: got %b expected 1", almost_full); end
    af_thresh = 3'd5; ae_thresh = 3'd0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_hwm();
    logic [USZ-1:0] exp3;
    logic [USZ-1:0] exp1;
`ifdef SD_TAILWR_HWM_EN
    exp3 = 3'd3; exp1 = 3'd1;
`else
    exp3 = 3'd0; exp1 = 3'd0;
`endif
    hwm_clr = 1'b1; cyc(1'b0, 8'h00, 1'b0, 1'b0); hwm_clr = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (hwm !== exp3) begin errors++; $display("FAIL hwm_peak: got %0d expected %0d", hwm, exp3); end
    hwm_clr = 1'b1; cyc(1'b0, 8'h00, 1'b0, 1'b0); hwm_clr = 1'b0;
    checks++; if (hwm !== 3'd0) begin errors++; $display("FAIL hwm_clear: got %0d expected 0", hwm); end
    cyc(1'b1, 8'h7F, 1'b0, 1'b0);
    checks++; if (hwm !== exp1) begin errors++; $display("FAIL hwm_one: got %0d expected %0d", hwm, exp1); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_back_to_back();
    test_flush();
    test_thresholds();
    test_hwm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
